// File: rtl/rot_pkg.sv
// Shared definitions for the rotation engine: tile geometry, pixel size,
// rotation mode encoding and the scheduler state type.
package rot_pkg;

  localparam int TILE      = 4;
  localparam int TILE_LOG2 = $clog2(TILE);
  localparam int BPP_LOG2  = 2;

  localparam logic [1:0] DEG_0   = 2'b00;
  localparam logic [1:0] DEG_90  = 2'b01;
  localparam logic [1:0] DEG_180 = 2'b10;
  localparam logic [1:0] DEG_270 = 2'b11;

  typedef enum logic [3:0] {
    IDLE,
    CHECK,
    RD_REQ,
    RD_WAIT,
    CORE,
    WR_REQ,
    WR_WAIT,
    NEXT,
    FIN
  } state_t;

  // Counter-clockwise turns a quarter turn one way into the other way.
  function automatic logic [1:0] eff_mode(input logic [1:0] degrees, input logic direction);
    return (direction && degrees[0]) ? {~degrees[1], degrees[0]} : degrees;
  endfunction

endpackage

// File: rtl/rot_dst_addr.sv
// Registered destination-address stage: maps the current source tile and row
// to the byte address of the matching row in the rotated destination tile.
module rot_dst_addr
  import rot_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DIM_W  = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [1:0]           mode,
  input  logic [DIM_W-1:0]     tx,
  input  logic [DIM_W-1:0]     ty,
  input  logic [TILE_LOG2-1:0] row,
  input  logic [DIM_W-1:0]     tw,
  input  logic [DIM_W-1:0]     th,
  input  logic [DIM_W-1:0]     width,
  input  logic [DIM_W-1:0]     height,
  input  logic [ADDR_W-1:0]    dst_base,
  output logic [ADDR_W-1:0]    addr
);

  logic [DIM_W-1:0]  dx;
  logic [DIM_W-1:0]  dy;
  logic [DIM_W-1:0]  pitch;
  logic [ADDR_W-1:0] pix;

  always_comb begin
    dx    = tx;
    dy    = ty;
    pitch = width;
    case (mode)
      DEG_90: begin
        dx    = th - DIM_W'(1) - ty;
        dy    = tx;
        pitch = height;
      end
      DEG_180: begin
        dx    = tw - DIM_W'(1) - tx;
        dy    = th - DIM_W'(1) - ty;
        pitch = width;
      end
      DEG_270: begin
        dx    = ty;
        dy    = tw - DIM_W'(1) - tx;
        pitch = height;
      end
      default: ;
    endcase
    pix = ((ADDR_W'(dy) << TILE_LOG2) + ADDR_W'(row)) * ADDR_W'(pitch)
        + (ADDR_W'(dx) << TILE_LOG2);
  end

  always_ff @(posedge clock) begin
    if (reset) addr <= '0;
    else       addr <= dst_base + (pix << BPP_LOG2);
  end

endmodule

// File: rtl/rot_tile_scheduler.sv
// Tile-by-tile sequencer for the rotation datapath: issues row-burst reads,
// kicks the pixel core, then issues row-burst writes into the rotated tile.
module rot_tile_scheduler
  import rot_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DIM_W  = 16
) (
  input  logic                 I_HCLK,
  input  logic                 I_HRESET,
  input  logic                 I_START,
  input  logic                 I_ABORT,
  input  logic [ADDR_W-1:0]    I_SRC_BASE,
  input  logic [ADDR_W-1:0]    I_DST_BASE,
  input  logic [DIM_W-1:0]     I_WIDTH,
  input  logic [DIM_W-1:0]     I_HEIGHT,
  input  logic [1:0]           I_DEGREES,
  input  logic                 I_DIRECTION,
  output logic                 O_DMA_REQ,
  output logic [ADDR_W-1:0]    O_DMA_ADDR,
  output logic                 O_DMA_WRITE,
  output logic [TILE_LOG2-1:0] O_DMA_ROW,
  input  logic                 I_DMA_ACK,
  input  logic                 I_DMA_DONE,
  output logic                 O_CORE_START,
  input  logic                 I_CORE_DONE,
  output logic                 O_BUSY,
  output logic                 O_DONE,
  output logic                 O_ERR
);

  state_t               state_q;
  logic [ADDR_W-1:0]    src_q;
  logic [ADDR_W-1:0]    dst_q;
  logic [DIM_W-1:0]     w_q;
  logic [DIM_W-1:0]     h_q;
  logic [DIM_W-1:0]     tw_q;
  logic [DIM_W-1:0]     th_q;
  logic [DIM_W-1:0]     tx_q;
  logic [DIM_W-1:0]     ty_q;
  logic [1:0]           mode_q;
  logic [TILE_LOG2-1:0] row_q;
  logic [TILE_LOG2-1:0] dst_row;
  logic [ADDR_W-1:0]    wr_addr;
  logic                 dims_bad;
  logic                 tx_wrap;
  logic                 last_tile;
  logic [DIM_W-1:0]     tx_inc;
  logic [DIM_W-1:0]     ty_inc;
  logic [DIM_W-1:0]     tx_nxt;
  logic [DIM_W-1:0]     ty_nxt;

  function automatic logic [ADDR_W-1:0] rd_addr(input logic [ADDR_W-1:0] base,
                                                input logic [DIM_W-1:0] width,
                                                input logic [DIM_W-1:0] tx,
                                                input logic [DIM_W-1:0] ty,
                                                input logic [TILE_LOG2-1:0] row);
    logic [ADDR_W-1:0] pix;
    pix = ((ADDR_W'(ty) << TILE_LOG2) + ADDR_W'(row)) * ADDR_W'(width)
        + (ADDR_W'(tx) << TILE_LOG2);
    return base + (pix << BPP_LOG2);
  endfunction

  // The destination stage is fed the row the FSM is about to move to, so its
  // registered address is ready on the first WR_REQ cycle.
  always_comb begin
    dims_bad  = (w_q == '0) || (h_q == '0) ||
                (w_q[TILE_LOG2-1:0] != '0) || (h_q[TILE_LOG2-1:0] != '0);
    tx_inc    = tx_q + DIM_W'(1);
    ty_inc    = ty_q + DIM_W'(1);
    tx_wrap   = (tx_inc == tw_q);
    tx_nxt    = tx_wrap ? '0 : tx_inc;
    ty_nxt    = tx_wrap ? ty_inc : ty_q;
    last_tile = tx_wrap && (ty_inc == th_q);
    dst_row   = (state_q == WR_WAIT && I_DMA_DONE) ? row_q + TILE_LOG2'(1) : row_q;
  end

  rot_dst_addr #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) u_dst_addr (
    .clock    (I_HCLK),
    .reset    (I_HRESET),
    .mode     (mode_q),
    .tx       (tx_q),
    .ty       (ty_q),
    .row      (dst_row),
    .tw       (tw_q),
    .th       (th_q),
    .width    (w_q),
    .height   (h_q),
    .dst_base (dst_q),
    .addr     (wr_addr)
  );

  always_ff @(posedge I_HCLK) begin
    if (I_HRESET) begin
      state_q      <= IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      w_q          <= '0;
      h_q          <= '0;
      tw_q         <= '0;
      th_q         <= '0;
      tx_q         <= '0;
      ty_q         <= '0;
      mode_q       <= DEG_0;
      row_q        <= '0;
      O_DMA_REQ    <= 1'b0;
      O_DMA_ADDR   <= '0;
      O_DMA_WRITE  <= 1'b0;
      O_DMA_ROW    <= '0;
      O_CORE_START <= 1'b0;
      O_BUSY       <= 1'b0;
      O_DONE       <= 1'b0;
      O_ERR        <= 1'b0;
    end else if (I_ABORT) begin
      state_q      <= IDLE;
      O_DMA_REQ    <= 1'b0;
      O_CORE_START <= 1'b0;
      O_BUSY       <= 1'b0;
      O_DONE       <= 1'b0;
    end else begin
      O_CORE_START <= 1'b0;
      O_DONE       <= 1'b0;
      case (state_q)
        IDLE: if (I_START) begin
          src_q   <= I_SRC_BASE;
          dst_q   <= I_DST_BASE;
          w_q     <= I_WIDTH;
          h_q     <= I_HEIGHT;
          mode_q  <= eff_mode(I_DEGREES, I_DIRECTION);
          O_BUSY  <= 1'b1;
          O_ERR   <= 1'b0;
          state_q <= CHECK;
        end
        CHECK: if (dims_bad) begin
          O_ERR   <= 1'b1;
          O_BUSY  <= 1'b0;
          state_q <= IDLE;
        end else begin
          tw_q        <= w_q >> TILE_LOG2;
          th_q        <= h_q >> TILE_LOG2;
          tx_q        <= '0;
          ty_q        <= '0;
          row_q       <= '0;
          O_DMA_REQ   <= 1'b1;
          O_DMA_WRITE <= 1'b0;
          O_DMA_ROW   <= '0;
          O_DMA_ADDR  <= rd_addr(src_q, w_q, '0, '0, '0);
          state_q     <= RD_REQ;
        end
        RD_REQ: if (O_DMA_REQ && I_DMA_ACK) begin
          O_DMA_REQ <= 1'b0;
          state_q   <= RD_WAIT;
        end
        RD_WAIT: if (I_DMA_DONE) begin
          row_q <= row_q + TILE_LOG2'(1);
          if (row_q == TILE_LOG2'(TILE - 1)) begin
            O_CORE_START <= 1'b1;
            state_q      <= CORE;
          end else begin
            O_DMA_REQ   <= 1'b1;
            O_DMA_WRITE <= 1'b0;
            O_DMA_ROW   <= row_q + TILE_LOG2'(1);
            O_DMA_ADDR  <= rd_addr(src_q, w_q, tx_q, ty_q, row_q + TILE_LOG2'(1));
            state_q     <= RD_REQ;
          end
        end
        CORE: if (I_CORE_DONE) begin
          row_q   <= '0;
          state_q <= WR_REQ;
        end
        // First WR_REQ cycle only loads the freshly computed address.
        WR_REQ: if (!O_DMA_REQ) begin
          O_DMA_REQ   <= 1'b1;
          O_DMA_WRITE <= 1'b1;
          O_DMA_ROW   <= row_q;
          O_DMA_ADDR  <= wr_addr;
        end else if (I_DMA_ACK) begin
          O_DMA_REQ <= 1'b0;
          state_q   <= WR_WAIT;
        end
        WR_WAIT: if (I_DMA_DONE) begin
          row_q   <= row_q + TILE_LOG2'(1);
          state_q <= (row_q == TILE_LOG2'(TILE - 1)) ? NEXT : WR_REQ;
        end
        NEXT: if (last_tile) begin
          state_q <= FIN;
        end else begin
          tx_q        <= tx_nxt;
          ty_q        <= ty_nxt;
          row_q       <= '0;
          O_DMA_REQ   <= 1'b1;
          O_DMA_WRITE <= 1'b0;
          O_DMA_ROW   <= '0;
          O_DMA_ADDR  <= rd_addr(src_q, w_q, tx_nxt, ty_nxt, '0);
          state_q     <= RD_REQ;
        end
        FIN: begin
          O_DONE  <= 1'b1;
          O_BUSY  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rot_tile_scheduler.sv
// Directed bench for rot_tile_scheduler: a DMA/core responder (auto or manual)
// plus a request logger, with hand-computed address expectations.
module tb_rot_tile_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [31:0] src_base;
  logic [31:0] dst_base;
  logic [15:0] width;
  logic [15:0] height;
  logic [1:0]  degrees;
  logic        direction;
  logic        dma_req;
  logic [31:0] dma_addr;
  logic        dma_write;
  logic [1:0]  dma_row;
  logic        dma_ack;
  logic        dma_done;
  logic        core_start;
  logic        core_done;
  logic        busy;
  logic        done;
  logic        err;

  logic        auto_en;
  logic        auto_ack, auto_done, auto_core_done;
  logic        man_ack, man_done, man_core_done;
  logic        req_prev;

  logic [31:0] rd_q[$];
  logic [1:0]  rd_row_q[$];
  logic [31:0] wr_q[$];
  int          done_cnt, core_cnt;
  int          n_compared, n_failed;
  int          base_rd, base_wr, base_done, base_core;
  logic        stable;
  logic [31:0] exp_a[8];
  logic [31:0] exp_b[8];

  assign dma_ack   = auto_en ? auto_ack : man_ack;
  assign dma_done  = auto_en ? auto_done : man_done;
  assign core_done = auto_en ? auto_core_done : man_core_done;

  always #5 clk = ~clk;

  rot_tile_scheduler #(.ADDR_W(32), .DIM_W(16)) dut (
    .I_HCLK       (clk),
    .I_HRESET     (reset),
    .I_START      (start),
    .I_ABORT      (abort),
    .I_SRC_BASE   (src_base),
    .I_DST_BASE   (dst_base),
    .I_WIDTH      (width),
    .I_HEIGHT     (height),
    .I_DEGREES    (degrees),
    .I_DIRECTION  (direction),
    .O_DMA_REQ    (dma_req),
    .O_DMA_ADDR   (dma_addr),
    .O_DMA_WRITE  (dma_write),
    .O_DMA_ROW    (dma_row),
    .I_DMA_ACK    (dma_ack),
    .I_DMA_DONE   (dma_done),
    .O_CORE_START (core_start),
    .I_CORE_DONE  (core_done),
    .O_BUSY       (busy),
    .O_DONE       (done),
    .O_ERR        (err)
  );

  // Responder acks every request at once and reports burst completion one
  // cycle later; the logger records each new request with its address.
  initial begin
    auto_ack = 1'b0; auto_done = 1'b0; auto_core_done = 1'b0;
    req_prev = 1'b0; done_cnt = 0; core_cnt = 0;
    forever begin
      @(negedge clk);
      if (dma_req && !req_prev) begin
        if (dma_write) wr_q.push_back(dma_addr);
        else begin
          rd_q.push_back(dma_addr);
          rd_row_q.push_back(dma_row);
        end
      end
      req_prev = dma_req;
      if (done) done_cnt++;
      if (core_start) core_cnt++;
      if (auto_en) begin
        auto_done      = auto_ack;
        auto_ack       = dma_req;
        auto_core_done = core_start;
      end else begin
        auto_done = 1'b0; auto_ack = 1'b0; auto_core_done = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_failed++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] w, input logic [15:0] h, input logic [1:0] deg,
                               input logic dir, input logic [31:0] src, input logic [31:0] dst);
    @(negedge clk);
    width = w; height = h; degrees = deg; direction = dir;
    src_base = src; dst_base = dst; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic snapBases();
    base_rd = rd_q.size(); base_wr = wr_q.size();
    base_done = done_cnt; base_core = core_cnt;
  endtask

  task automatic waitDone(input string tag, input int limit);
    int n = 0;
    while (done_cnt == base_done && n < limit) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 32'(done_cnt - base_done), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic dmaXfer(input string tag);
    int n = 0;
    while (dma_req !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 32'(dma_req), 32'd1);
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0; man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
  endtask

  initial begin
    n_compared = 0; n_failed = 0;
    reset = 1'b1; start = 1'b0; abort = 1'b0; auto_en = 1'b1;
    man_ack = 1'b0; man_done = 1'b0; man_core_done = 1'b0;
    src_base = '0; dst_base = '0; width = '0; height = '0; degrees = '0; direction = 1'b0;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_req", 32'(dma_req), 32'd0);
    checkOutput("rst_addr", dma_addr, 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_core_start", 32'(core_start), 32'd0);

    $display("[TB] job 8x8, 0 degrees");
    snapBases();
    applyStimulus(16'd8, 16'd8, 2'b00, 1'b0, 32'h1000, 32'h2000);
    checkOutput("lat_busy", 32'(busy), 32'd1);
    checkOutput("lat_req_c1", 32'(dma_req), 32'd0);
    @(negedge clk);
    checkOutput("lat_req_c2", 32'(dma_req), 32'd1);
    checkOutput("lat_addr", dma_addr, 32'h1000);
    waitDone("j1_done_seen", 2000);
    checkOutput("j1_reads", 32'(rd_q.size() - base_rd), 32'd16);
    checkOutput("j1_writes", 32'(wr_q.size() - base_wr), 32'd16);
    checkOutput("j1_core_starts", 32'(core_cnt - base_core), 32'd4);
    checkOutput("j1_done_once", 32'(done_cnt - base_done), 32'd1);
    checkOutput("j1_busy_end", 32'(busy), 32'd0);
    checkOutput("j1_rd0", rd_q[base_rd + 0], 32'h1000);
    checkOutput("j1_rd1", rd_q[base_rd + 1], 32'h1020);
    checkOutput("j1_rd2", rd_q[base_rd + 2], 32'h1040);
    checkOutput("j1_rd3", rd_q[base_rd + 3], 32'h1060);
    checkOutput("j1_rd1_row", 32'(rd_row_q[base_rd + 1]), 32'd1);
    checkOutput("j1_rd4", rd_q[base_rd + 4], 32'h1010);
    checkOutput("j1_rd8", rd_q[base_rd + 8], 32'h1080);
    checkOutput("j1_wr0", wr_q[base_wr + 0], 32'h2000);
    checkOutput("j1_wr4", wr_q[base_wr + 4], 32'h2010);
    checkOutput("j1_wr15", wr_q[base_wr + 15], 32'h20F0);

    $display("[TB] job 8x4, 90 cw / 90 ccw / 270 cw");
    exp_a = '{32'h00, 32'h10, 32'h20, 32'h30, 32'h40, 32'h50, 32'h60, 32'h70};
    exp_b = '{32'h40, 32'h50, 32'h60, 32'h70, 32'h00, 32'h10, 32'h20, 32'h30};
    snapBases();
    applyStimulus(16'd8, 16'd4, 2'b01, 1'b0, 32'h0, 32'h0);
    waitDone("r90_done_seen", 1000);
    checkOutput("r90_writes", 32'(wr_q.size() - base_wr), 32'd8);
    for (int i = 0; i < 8; i++) checkOutput($sformatf("r90_wr%0d", i), wr_q[base_wr + i], exp_a[i]);
    snapBases();
    applyStimulus(16'd8, 16'd4, 2'b01, 1'b1, 32'h0, 32'h0);
    waitDone("r90ccw_done_seen", 1000);
    for (int i = 0; i < 8; i++) checkOutput($sformatf("r90ccw_wr%0d", i), wr_q[base_wr + i], exp_b[i]);
    snapBases();
    applyStimulus(16'd8, 16'd4, 2'b11, 1'b0, 32'h0, 32'h0);
    waitDone("r270_done_seen", 1000);
    for (int i = 0; i < 8; i++) checkOutput($sformatf("r270_wr%0d", i), wr_q[base_wr + i], exp_b[i]);

    $display("[TB] bad dimensions 6x8");
    snapBases();
    applyStimulus(16'd6, 16'd8, 2'b00, 1'b0, 32'h1000, 32'h2000);
    checkOutput("err_c1_err", 32'(err), 32'd0);
    checkOutput("err_c1_busy", 32'(busy), 32'd1);
    @(negedge clk);
    checkOutput("err_c2_err", 32'(err), 32'd1);
    checkOutput("err_c2_busy", 32'(busy), 32'd0);
    repeat (10) @(negedge clk);
    checkOutput("err_no_req", 32'(rd_q.size() + wr_q.size() - base_rd - base_wr), 32'd0);
    checkOutput("err_no_done", 32'(done_cnt - base_done), 32'd0);
    checkOutput("err_sticky", 32'(err), 32'd1);
    snapBases();
    applyStimulus(16'd4, 16'd4, 2'b00, 1'b0, 32'h100, 32'h200);
    checkOutput("err_cleared", 32'(err), 32'd0);
    waitDone("err_rerun_done_seen", 1000);
    checkOutput("err_rerun_reads", 32'(rd_q.size() - base_rd), 32'd4);
    checkOutput("err_rerun_wr0", wr_q[base_wr], 32'h200);

    $display("[TB] withheld ack, spurious done, abort in RD_REQ");
    auto_en = 1'b0;
    applyStimulus(16'd4, 16'd4, 2'b00, 1'b0, 32'h3000, 32'h6000);
    @(negedge clk);
    checkOutput("hold_req_up", 32'(dma_req), 32'd1);
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      man_done = (i == 2);
      @(negedge clk);
      if (!(dma_req === 1'b1 && dma_addr === 32'h3000)) stable = 1'b0;
    end
    man_done = 1'b0;
    checkOutput("hold_stable_5", 32'(stable), 32'd1);
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    checkOutput("hold_req_drop", 32'(dma_req), 32'd0);
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    checkOutput("hold_rd2_req", 32'(dma_req), 32'd1);
    checkOutput("hold_rd2_addr", dma_addr, 32'h3010);
    checkOutput("hold_rd2_row", 32'(dma_row), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort_rd_req", 32'(dma_req), 32'd0);
    checkOutput("abort_rd_busy", 32'(busy), 32'd0);

    $display("[TB] abort during WR_WAIT, then full 180 job");
    snapBases();
    applyStimulus(16'd4, 16'd4, 2'b00, 1'b0, 32'h4000, 32'h5000);
    for (int i = 0; i < 4; i++) dmaXfer($sformatf("t7_rd%0d_req", i));
    checkOutput("t7_core_start", 32'(core_start), 32'd1);
    man_core_done = 1'b1;
    @(negedge clk);
    man_core_done = 1'b0;
    for (int n = 0; n < 20 && dma_req !== 1'b1; n++) @(negedge clk);
    checkOutput("t7_wr_req", 32'(dma_req), 32'd1);
    checkOutput("t7_wr_write", 32'(dma_write), 32'd1);
    checkOutput("t7_wr_addr", dma_addr, 32'h5000);
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    abort = 1'b1; man_done = 1'b1;
    @(negedge clk);
    abort = 1'b0; man_done = 1'b0;
    checkOutput("t7_abort_busy", 32'(busy), 32'd0);
    checkOutput("t7_abort_req", 32'(dma_req), 32'd0);
    repeat (5) @(negedge clk);
    checkOutput("t7_no_done", 32'(done_cnt - base_done), 32'd0);
    checkOutput("t7_idle_req", 32'(dma_req), 32'd0);
    auto_en = 1'b1;
    snapBases();
    applyStimulus(16'd8, 16'd8, 2'b10, 1'b0, 32'h1000, 32'h2000);
    waitDone("r180_done_seen", 2000);
    checkOutput("r180_reads", 32'(rd_q.size() - base_rd), 32'd16);
    checkOutput("r180_writes", 32'(wr_q.size() - base_wr), 32'd16);
    checkOutput("r180_wr0", wr_q[base_wr + 0], 32'h2090);
    checkOutput("r180_wr1", wr_q[base_wr + 1], 32'h20B0);
    checkOutput("r180_wr4", wr_q[base_wr + 4], 32'h2080);
    checkOutput("r180_wr15", wr_q[base_wr + 15], 32'h2060);
    checkOutput("r180_done_once", 32'(done_cnt - base_done), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
